// File: rtl/i2c_eeprom_slave.sv
// I2C responder emulating a 512-byte AT24C04-class EEPROM (byte/page write, current/random/sequential read).
// Define I2C_EEPROM_WRBUSY_EN to emulate the internal write cycle, which NACKs address polling while it runs.
module i2c_eeprom_slave #(
   parameter logic [3:0] DEV_ID      = 4'b1010,
   parameter logic [1:0] HW_ADDR     = 2'b00,
   parameter int         PAGE        = 16,
   parameter int         WR_BUSY_CYC = 5000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   inout  wire        sda,
   output logic       busy,
   output logic       mem_we,
   output logic [8:0] mem_addr,
   output logic [7:0] mem_wdata
);
   typedef enum logic [3:0] {
      IDLE, DEV_ADDR, DEV_ACK, WORD_ADDR, WORD_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
   } state_t;

   localparam logic [8:0] PG_MASK = 9'(PAGE - 1);

   state_t     state_q;
   logic [2:0] scl_q, sda_q;   // [1:0] synchronizer, [2] previous synchronized value
   logic       fall_dly_q;
   logic [7:0] shift_q;
   logic [6:0] tx_q;
   logic [7:0] rd_data_q;
   logic [2:0] bit_cnt_q;
   logic [8:0] ptr_q;
   logic       sda_oe_q, busy_q, ack_drv_q, mack_q, rw_q, mem_we_q;
   logic [8:0] mem_addr_q;
   logic [7:0] mem_wdata_q;
   logic [7:0] mem [512] = '{default: 8'hFF};

   logic       scl_rise, scl_fall, start_det, stop_det, dev_match, wr_blocked;
   logic [7:0] byte_in;

   assign scl_rise  = scl_q[1] & ~scl_q[2];
   assign scl_fall  = ~scl_q[1] & scl_q[2];
   assign start_det = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
   assign stop_det  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
   assign byte_in   = {shift_q[6:0], sda_q[1]};
   assign dev_match = (byte_in[7:4] == DEV_ID) && (byte_in[3:2] == HW_ADDR) && !wr_blocked;

   assign sda       = sda_oe_q ? 1'b0 : 1'bz;
   assign busy      = busy_q | wr_blocked;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         scl_q       <= 3'b111;
         sda_q       <= 3'b111;
         fall_dly_q  <= 1'b0;
         shift_q     <= '0;
         tx_q        <= '0;
         bit_cnt_q   <= '0;
         ptr_q       <= '0;
         sda_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         ack_drv_q   <= 1'b0;
         mack_q      <= 1'b0;
         rw_q        <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         scl_q      <= {scl_q[1:0], sclk};
         sda_q      <= {sda_q[1:0], sda};
         fall_dly_q <= scl_fall;
         mem_we_q   <= 1'b0;
         if (stop_det) begin
            state_q  <= IDLE;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
         end else if (start_det) begin
            state_q   <= DEV_ADDR;
            sda_oe_q  <= 1'b0;
            bit_cnt_q <= '0;
            ack_drv_q <= 1'b0;
            mack_q    <= 1'b0;
         end else begin
            case (state_q)
               IDLE: busy_q <= 1'b0;
               DEV_ADDR, WORD_ADDR, WR_DATA: begin
                  if (scl_rise) begin
                     shift_q   <= byte_in;
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        ack_drv_q <= 1'b0;
                        case (state_q)
                           DEV_ADDR: begin
                              if (dev_match) begin
                                 state_q <= DEV_ACK;
                                 busy_q  <= 1'b1;
                                 rw_q    <= byte_in[0];
                                 if (!byte_in[0]) ptr_q[8] <= byte_in[1];
                              end else begin
                                 state_q <= IDLE;
                                 busy_q  <= 1'b0;
                              end
                           end
                           WORD_ADDR: begin
                              ptr_q[7:0] <= byte_in;
                              state_q    <= WORD_ACK;
                           end
                           default: state_q <= WR_ACK;
                        endcase
                     end
                  end
               end
               DEV_ACK, WORD_ACK, WR_ACK: begin
                  if (fall_dly_q) begin
                     if (!ack_drv_q) begin
                        ack_drv_q <= 1'b1;
                        sda_oe_q  <= 1'b1;
                        if (state_q == WR_ACK) begin
                           // page write: only the in-page offset advances
                           mem_we_q    <= 1'b1;
                           mem_addr_q  <= ptr_q;
                           mem_wdata_q <= shift_q;
                           ptr_q       <= (ptr_q & ~PG_MASK) | ((ptr_q + 9'd1) & PG_MASK);
                        end
                     end else begin
                        ack_drv_q <= 1'b0;
                        bit_cnt_q <= '0;
                        if (state_q == DEV_ACK && rw_q) begin
                           state_q  <= RD_DATA;
                           tx_q     <= rd_data_q[6:0];
                           sda_oe_q <= ~rd_data_q[7];
                        end else begin
                           sda_oe_q <= 1'b0;
                           state_q  <= (state_q == DEV_ACK) ? WORD_ADDR : WR_DATA;
                        end
                     end
                  end
               end
               RD_DATA: begin
                  if (scl_rise) begin
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        state_q <= RD_ACK;
                        ptr_q   <= ptr_q + 9'd1;
                        mack_q  <= 1'b0;
                     end
                  end else if (fall_dly_q) begin
                     tx_q     <= {tx_q[5:0], 1'b1};
                     sda_oe_q <= ~tx_q[6];
                  end
               end
               RD_ACK: begin
                  if (scl_rise) begin
                     if (!sda_q[1]) begin
                        mack_q <= 1'b1;
                     end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                     end
                  end else if (fall_dly_q) begin
                     if (mack_q) begin
                        mack_q    <= 1'b0;
                        state_q   <= RD_DATA;
                        bit_cnt_q <= '0;
                        tx_q      <= rd_data_q[6:0];
                        sda_oe_q  <= ~rd_data_q[7];
                     end else begin
                        sda_oe_q <= 1'b0;
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   // Array is never reset; read data trails the pointer by one clk, long before it is needed.
   always_ff @(posedge clk) begin
      if (mem_we_q) mem[mem_addr_q] <= mem_wdata_q;
      rd_data_q <= mem[ptr_q];
   end

`ifdef I2C_EEPROM_WRBUSY_EN
   localparam int CW = $clog2(WR_BUSY_CYC + 1);
   logic [CW-1:0] wcnt_q;
   logic          wrote_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt_q  <= '0;
         wrote_q <= 1'b0;
      end else begin
         if (stop_det && wrote_q) begin
            wcnt_q  <= CW'(WR_BUSY_CYC);
            wrote_q <= 1'b0;
         end else if (wcnt_q != '0) begin
            wcnt_q <= wcnt_q - CW'(1);
         end
         if (mem_we_q) wrote_q <= 1'b1;
      end
   end
   assign wr_blocked = (wcnt_q != '0);
`else
   logic unused_wr_busy;
   assign unused_wr_busy = (WR_BUSY_CYC != 0);
   assign wr_blocked     = 1'b0;
`endif
endmodule

// File: doc/i2c_eeprom_slave.md
Name: i2c_eeprom_slave

Overview:
- I2C responder emulating a 512-byte AT24C04-class EEPROM.
- Sits on the same SDA/SCL pair as the existing I2C master and EEPROM client, so that master can be exercised on-chip and in simulation without a physical EEPROM.
- Supports byte/page write, current-address read, random read and sequential read, with ACK/NACK signalling.

Parameters:
- DEV_ID, 4'b1010, fixed device-type bits [7:4] of the address byte.
- HW_ADDR, 2'b00, A2/A1 strap bits compared against address-byte bits [3:2].
- PAGE, 16, page-write size in bytes (power of two).
- WR_BUSY_CYC, 5000, clk cycles of emulated write cycle (optional feature only).

Ports:
- clk  input  1  system clock; must be ≥16× SCL frequency.
- rst  input  1  asynchronous, active-high reset.
- sclk  input  1  I2C clock from the master.
- sda  inout  1  I2C data; open-drain, driven only 1'b0 or 1'bz.
- busy  output  1  high from an addressed START until STOP or NACK.
- mem_we  output  1  one-cycle pulse when a data byte is committed.
- mem_addr  output  9  address of the committed byte.
- mem_wdata  output  8  committed byte value.

Behaviour:
- Input conditioning and bus events:
  - sclk and sda pass through 2-flop synchronizers; edges are detected from the synchronized copies.
  - START: sda falls while sclk is high. STOP: sda rises while sclk is high. Both are detected in any state.
- SDA timing:
  - Bits are sampled on the sclk rising edge, MSB first.
  - The slave changes its sda drive only one clk after a detected sclk falling edge.
- Reset:
  - State IDLE, sda released (z), busy=0, mem_we=0, mem_addr=0, mem_wdata=0, pointer=0.
  - Memory array is not cleared by rst; it is initialised to 8'hFF at time zero.
- States:
  - IDLE: wait for START, then go to DEV_ADDR.
  - DEV_ADDR: shift 8 bits.
    - Match means [7:4]==DEV_ID and [3:2]==HW_ADDR; go to DEV_ACK.
    - Mismatch: leave sda released (NACK) and go to IDLE.
  - DEV_ACK: drive sda=0 for the 9th clock and release it on the following sclk fall.
    - R/W=0 (write): pointer[8] ← address-byte bit 1 (P0); next state WORD_ADDR.
    - R/W=1 (read): pointer unchanged; next state RD_DATA.
  - WORD_ADDR: shift 8 bits into pointer[7:0], then WORD_ACK (ACK), then WR_DATA.
  - WR_DATA: shift 8 bits, then WR_ACK.
    - At the ACK drive, pulse mem_we with mem_addr=pointer and mem_wdata=byte; the array is written the same cycle.
    - pointer[3:0] increments modulo PAGE; upper bits are held, so a page write wraps within its page.
  - RD_DATA: present mem[pointer] MSB first (bit 0 → drive 0, bit 1 → release).
    - After the 8th bit, release sda; pointer increments modulo 512 (0x1FF→0x000).
    - Go to RD_ACK.
  - RD_ACK: sample master bit on sclk rise. 0 (ACK) → RD_DATA with next byte; 1 (NACK) → IDLE.
- START in any non-IDLE state (repeated start): sda released and go to DEV_ADDR. The pointer is kept, so a random read works.
- STOP in any state: sda released, IDLE, busy=0.
  - A partially shifted byte is discarded; bytes already committed remain written.
- busy: set on a matching DEV_ACK; cleared on STOP, on entering IDLE, or on rst.
- rst mid-transfer: sda released within the same clk (asynchronous); no further mem_we.

Optional Feature:
- Macro: I2C_EEPROM_WRBUSY_EN.
- Defined:
  - A STOP following at least one committed write byte starts a WR_BUSY_CYC-cycle counter.
  - While the counter is nonzero, a matching device address is NACKed (acknowledge polling) and busy stays high.
  - rst clears the counter.
- Undefined: the counter logic is absent; the device ACKs immediately after STOP.

Test Plan:
- Page write: START, 0xA0, 0x20, data 0x00..0x0F, STOP → 18 ACKs; mem 0x020..0x02F = 0x00..0x0F; 16 mem_we pulses.
- Page wrap: START, 0xA0, 0x0E, 4 bytes 0x11,0x22,0x33,0x44, STOP → mem 0x00E=0x11, 0x00F=0x22, 0x000=0x33, 0x001=0x44.
- Random and sequential read:
  - Sequence: write-address 0xA2/0xFE, repeated START, 0xA1, read 3 bytes with ACK, ACK, NACK.
  - Bytes returned are mem 0x1FE, 0x1FF, 0x000; pointer ends at 0x001.
- Address mismatch: 0xA4 with HW_ADDR=00 → sda stays high on the 9th clock; no mem_we; busy=0.
- Reset mid-read: assert rst while the slave drives sda=0 → sda=z the same cycle; next 0xA1 read returns mem[0x000].
- With I2C_EEPROM_WRBUSY_EN defined:
  - 0xA0 immediately after a write STOP → NACK.
  - After WR_BUSY_CYC cycles → ACK.
